// File: rtl/clint_rtc_gen.sv
// Fractional real-time clock generator for the CLINT rt_clk input.
// 32-bit phase accumulator with a small valid/ready register slave.
module clint_rtc_gen #(
  parameter int          ADDR_W       = 32,
  parameter int          DATA_W       = 32,
  parameter logic [31:0] INCR_RESET   = 32'h0015_798F,
  parameter logic        ENABLE_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                rt_clk,
  output logic                rtc_tick
);

  typedef enum logic [1:0] {
    R_CTRL  = 2'd0,
    R_INCR  = 2'd1,
    R_ACC   = 2'd2,
    R_TICKS = 2'd3
  } reg_e;

  logic [31:0]       acc_q, acc_d;
  logic [31:0]       incr_q, incr_d;
  logic [31:0]       ticks_q, ticks_d;
  logic              en_q, en_d;
  logic              tick_q, tick_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  reg_e        sel;
  logic        wr, rd, rise;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign unused_addr = ^{address[ADDR_W-1:4], address[1:0]};

  always_comb begin
    sel     = reg_e'(address[3:2]);
    wr      = valid && (wstrb == {(DATA_W/8){1'b1}});
    rd      = valid && !wr;
    rd_mux  = '0;
    unique case (sel)
      R_CTRL:  rd_mux = {31'd0, en_q};
      R_INCR:  rd_mux = incr_q;
      R_ACC:   rd_mux = acc_q;
      R_TICKS: rd_mux = ticks_q;
    endcase

    en_d    = en_q;
    incr_d  = incr_q;
    if (wr && sel == R_CTRL) en_d = wdata[0];
    if (wr && sel == R_INCR) incr_d = wdata;

    // Clear wins over accumulation and uses pre-edge enable/incr.
    if (wr && sel == R_CTRL && wdata[1]) acc_d = '0;
    else if (en_q)                        acc_d = acc_q + incr_q;
    else                                  acc_d = acc_q;

    rise    = !acc_q[31] && acc_d[31];
    tick_d  = rise;

    // A software write to TICKS overrides a coincident increment.
    if (wr && sel == R_TICKS) ticks_d = wdata;
    else                      ticks_d = ticks_q + {31'd0, rise};

    ready_d = valid;
    rdata_d = rd ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      incr_q  <= INCR_RESET;
      en_q    <= ENABLE_RESET;
      ticks_q <= '0;
      tick_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      acc_q   <= acc_d;
      incr_q  <= incr_d;
      en_q    <= en_d;
      ticks_q <= ticks_d;
      tick_q  <= tick_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign rt_clk   = acc_q[31];
  assign rtc_tick = tick_q;
  assign ready    = ready_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_clint_rtc_gen.sv
// Directed bench for clint_rtc_gen.
// Hand-computed expectations for rt_clk, ticks and register reads.
module tb_clint_rtc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        rt_clk;
  logic        rtc_tick;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  clint_rtc_gen dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .address  (address),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .rdata    (rdata),
    .ready    (ready),
    .rt_clk   (rt_clk),
    .rtc_tick (rtc_tick)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic xfer(input logic [3:0] st, input logic [1:0] a,
                      input logic [31:0] d);
    valid   = 1'b1;
    address = {28'd0, a, 2'b00};
    wdata   = d;
    wstrb   = st;
    @(posedge clk);
    #1;
    valid   = 1'b0;
    wstrb   = 4'h0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    xfer(4'hF, a, d);
    check("wr_ready", {31'd0, ready}, 32'd1);
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [31:0] exp);
    xfer(4'h0, a, 32'd0);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check(tag, rdata, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset   = 1'b1;
    valid   = 1'b0;
    address = '0;
    wdata   = '0;
    wstrb   = '0;
    idle(2);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rtclk", {31'd0, rt_clk}, 32'd0);
    check("rst_tick", {31'd0, rtc_tick}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset = 1'b0;

    rd("rst_ticks", 2'd3, 32'd0);
    rd("rst_incr", 2'd1, 32'h0015_798F);
    rd("rst_ctrl", 2'd0, 32'h1);

    // Quarter-phase increment: 4-clk rt_clk period after clear.
    wr(2'd1, 32'h4000_0000);
    wr(2'd0, 32'h3);
    check("clr_rtclk", {31'd0, rt_clk}, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rt_k%0d", k), {31'd0, rt_clk},
            {31'd0, (k % 4) >= 2});
      check($sformatf("tick_k%0d", k), {31'd0, rtc_tick},
            {31'd0, (k % 4) == 2});
    end
    rd("ticks20", 2'd3, 32'd5);

    // Disable on the edge that lands acc at 0x80000000.
    wr(2'd0, 32'h0);
    check("dis_rtclk", {31'd0, rt_clk}, 32'd1);
    check("dis_tick", {31'd0, rtc_tick}, 32'd1);
    rd("dis_acc", 2'd2, 32'h8000_0000);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("hold_rtclk", {31'd0, rt_clk}, 32'd1);
      check("hold_tick", {31'd0, rtc_tick}, 32'd0);
    end
    rd("hold_ticks", 2'd3, 32'd6);
    wr(2'd0, 32'h1);
    rd("res_acc0", 2'd2, 32'h8000_0000);
    rd("res_acc1", 2'd2, 32'hC000_0000);

    // TICKS wrap, with a write coinciding with a rising edge.
    wr(2'd1, 32'h8000_0000);
    wr(2'd0, 32'h3);
    wr(2'd3, 32'hFFFF_FFFF);
    check("coll_tick", {31'd0, rtc_tick}, 32'd1);
    rd("coll_ticks", 2'd3, 32'hFFFF_FFFF);
    idle(1);
    check("wrap_tick", {31'd0, rtc_tick}, 32'd1);
    rd("wrap_ticks", 2'd3, 32'd0);

    // Back-to-back read, write, read, partial-strobe read.
    rd("b2b_ctrl", 2'd0, 32'h1);
    wr(2'd1, 32'h1234_5678);
    check("b2b_wr_rdata", rdata, 32'h1);
    rd("b2b_incr", 2'd1, 32'h1234_5678);
    xfer(4'h3, 2'd1, 32'h0);
    check("strb3_ready", {31'd0, ready}, 32'd1);
    check("strb3_rdata", rdata, 32'h1234_5678);
    idle(1);
    check("idle_ready", {31'd0, ready}, 32'd0);
    check("idle_rdata", rdata, 32'h1234_5678);
    rd("strb3_incr", 2'd1, 32'h1234_5678);

    // Mid-run reset with acc at 0xC0000000 and a request pending.
    wr(2'd1, 32'h4000_0000);
    wr(2'd0, 32'h3);
    idle(3);
    check("pre_rst_rtclk", {31'd0, rt_clk}, 32'd1);
    reset   = 1'b1;
    valid   = 1'b1;
    address = 32'h4;
    wstrb   = 4'h0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    valid   = 1'b0;
    check("mrst_ready", {31'd0, ready}, 32'd0);
    check("mrst_rtclk", {31'd0, rt_clk}, 32'd0);
    check("mrst_rdata", rdata, 32'd0);
    rd("mrst_incr", 2'd1, 32'h0015_798F);
    rd("mrst_acc", 2'd2, 32'h0015_798F);
    rd("mrst_ctrl", 2'd0, 32'h1);
    rd("mrst_ticks", 2'd3, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
